blink_period_meter: RTL and testbench
=====================================

# blink_period_meter

Measures the period and high time of a slow, asynchronous square-wave input, such as the LED blink output of the clock frequency divider, in units of the system clock. It is the receiving end of the divided-clock/blink interface and gives self-checks and status logic a numeric readback of the blink rate. The block synchronises the input, detects its rising edges and reports each completed period with a one-cycle valid pulse. It also flags loss of activity.

## Interface
- `CNT_W`, default 27: width of the period and high-time counters and outputs.
- `TIMEOUT`, default 100000000: clk cycles without a rising edge before `timeout` asserts. Must satisfy 2 ≤ TIMEOUT ≤ 2^CNT_W − 1.
- `clk` in 1: system clock; all state is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `sig_in` in 1: asynchronous input being measured, e.g. the divider LED.
- `period` out CNT_W: clk cycles from one rising edge to the next, for the last completed period.
- `high_time` out CNT_W: clk cycles `sig_in` was high within that period.
- `meas_valid` out 1: one-cycle pulse when `period` and `high_time` update.
- `locked` out 1: high once at least one full period has been measured since reset or since the last timeout.
- `timeout` out 1: level signal; no rising edge seen for TIMEOUT cycles.

## Operation
- Synchroniser:
  - `sig_in` passes through two flops, `s1` then `s2`.
  - A third flop `s3` holds the previous `s2`.
  - `rise` = `s2 & ~s3`.
- State machine, two states:
  - WAIT_FIRST is entered on reset or on timeout. On `rise`: go to MEASURE, clear `cnt` to 0, set `hcnt` to 1, produce no `meas_valid`.
  - MEASURE, cycles without `rise`: `cnt` increments by 1; `hcnt` increments by 1 when `s2`=1.
  - MEASURE, cycle with `rise`: load `period` with `cnt`+1 and `high_time` with `hcnt`. Pulse `meas_valid`. Set `locked`=1 and clear `timeout`. Clear `cnt` to 0, set `hcnt` to 1, stay in MEASURE.
  - MEASURE, no `rise` while `cnt` == TIMEOUT−1: go to WAIT_FIRST, set `timeout`=1, clear `locked`. `period` and `high_time` keep their last values.
- In WAIT_FIRST:
  - `cnt` increments and saturates at TIMEOUT−1.
  - On reaching TIMEOUT−1, `timeout` sets to 1.
  - `timeout` stays set until the next `meas_valid`.
- Width rules:
  - Counters never wrap, because TIMEOUT ≤ 2^CNT_W − 1 bounds `cnt`.
  - `cnt`+1 is computed at CNT_W bits.
  - `high_time` ≤ `period` always.
- Simultaneous `rise` and `cnt` == TIMEOUT−1 in MEASURE: the edge wins. The measurement completes, `period` = TIMEOUT, and no timeout occurs.
- Reset mid-measurement aborts immediately. All partial counts are discarded.

## Timing
- Reset values:
  - `period`=0, `high_time`=0, `meas_valid`=0, `locked`=0, `timeout`=0.
  - State WAIT_FIRST, `s1`=`s2`=`s3`=0, `cnt`=0, `hcnt`=0.
- Latency: a `sig_in` rising edge that meets setup before clk edge N gives `rise` during cycle N+2. `meas_valid` and the new `period`/`high_time` are visible from cycle N+3.
- `meas_valid` is high for exactly one cycle per completed period. The earliest `meas_valid` comes after the second rising edge following reset.
- Minimum measurable period is 2 clk cycles, where `sig_in` toggles every cycle. This gives `period`=2 and `high_time`=1.
- A square wave with period P clk cycles (P < TIMEOUT) gives `period`=P on every `meas_valid`. `meas_valid` pulses are P cycles apart.
- `timeout` asserts TIMEOUT cycles after the last `rise`, counted as the cycle in which `cnt` reaches TIMEOUT−1 plus one register stage.

## Test plan
Bench parameters for all scenarios: TIMEOUT=50, CNT_W=27, clk period 10 ns.

1. Reset held for 2 cycles with `sig_in`=0, then released with no edges. Required: all outputs 0 until cycle 50, then `timeout`=1, with `locked`=0 and `meas_valid`=0 throughout.
2. `sig_in` toggles every 5 clks, a 50% duty square wave. Required: first `meas_valid` after the second rising edge; every `meas_valid` shows `period`=10, `high_time`=5; pulses 10 cycles apart; `locked`=1.
3. `sig_in` high for 3 cycles, low for 5, repeated. Required: `period`=8, `high_time`=3 on each `meas_valid`.
4. Lock on a 10-cycle wave, then hold `sig_in` low. Required: `timeout`=1 and `locked`=0 exactly 50 cycles after the last `rise`; `period` still reads 10. Resume toggling. Required: after two edges `meas_valid` with `period`=10, `timeout` cleared, `locked`=1.
5. `sig_in` toggles every cycle. Required: `period`=2 and `high_time`=1 on each `meas_valid`. Place edges so that `cnt`==49 coincides with `rise`. Required: `period`=50 and `timeout` stays 0.
6. Assert `reset` asynchronously midway through a measured period. Required: outputs go to 0 immediately, without waiting for a clk edge. After release, no `meas_valid` until two new rising edges have been seen.

Source files
------------

// File: rtl/blink_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles.
// Flags loss of activity when no rising edge is seen for TIMEOUT cycles.
module blink_period_meter #(
   parameter int unsigned CNT_W   = 27,
   parameter int unsigned TIMEOUT = 100000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             locked,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] One    = CNT_W'(1);

   typedef enum logic [0:0] {StWaitFirst, StMeasure} state_e;

   state_e           state_q, state_d;
   logic             s1_q, s2_q, s3_q;
   logic             rise;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             valid_q, valid_d;
   logic             locked_q, locked_d;
   logic             timeout_q, timeout_d;

   assign rise = s2_q & ~s3_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hcnt_d    = hcnt_q;
      period_d  = period_q;
      high_d    = high_q;
      valid_d   = 1'b0;
      locked_d  = locked_q;
      timeout_d = timeout_q;
      unique case (state_q)
         StWaitFirst: begin
            if (rise) begin
               state_d = StMeasure;
               cnt_d   = '0;
               hcnt_d  = One;
            end else if (cnt_q != CntMax) begin
               cnt_d = cnt_q + One;
            end else begin
               timeout_d = 1'b1;
            end
         end
         StMeasure: begin
            // An edge in the same cycle as the last count wins over the timeout.
            if (rise) begin
               period_d  = cnt_q + One;
               high_d    = hcnt_q;
               valid_d   = 1'b1;
               locked_d  = 1'b1;
               timeout_d = 1'b0;
               cnt_d     = '0;
               hcnt_d    = One;
            end else if (cnt_q == CntMax) begin
               state_d   = StWaitFirst;
               timeout_d = 1'b1;
               locked_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + One;
               if (s2_q) hcnt_d = hcnt_q + One;
            end
         end
         default: state_d = StWaitFirst;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StWaitFirst;
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         s3_q      <= 1'b0;
         cnt_q     <= '0;
         hcnt_q    <= '0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         s1_q      <= sig_in;
         s2_q      <= s1_q;
         s3_q      <= s2_q;
         cnt_q     <= cnt_d;
         hcnt_q    <= hcnt_d;
         period_q  <= period_d;
         high_q    <= high_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         timeout_q <= timeout_d;
      end
   end

   assign period     = period_q;
   assign high_time  = high_q;
   assign meas_valid = valid_q;
   assign locked     = locked_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_blink_period_meter.sv
// Bench for blink_period_meter: directed waveforms plus random pulse trains,
// all checked cycle by cycle against an edge-list reference model.
module tb_blink_period_meter;

   localparam int unsigned CNT_W = 27;
   localparam int          TO    = 50;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             sig_in = 1'b0;
   logic [CNT_W-1:0] period, high_time;
   logic             meas_valid, locked, timeout;

   always #5 clk = ~clk;

   blink_period_meter #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sig_in     (sig_in),
      .period     (period),
      .high_time  (high_time),
      .meas_valid (meas_valid),
      .locked     (locked),
      .timeout    (timeout)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: raw input per edge, synchronised view two edges later,
   // measurements derived from distances between rising edges of that view.
   bit               vq[$];
   bit               wq[$];
   bit               have_l;
   int               last_rise;
   logic [CNT_W-1:0] e_period, e_high;
   bit               e_mv, e_locked, e_to;

   function automatic void model_reset();
      vq.delete();
      wq.delete();
      have_l    = 1'b0;
      last_rise = 0;
      e_period  = '0;
      e_high    = '0;
      e_mv      = 1'b0;
      e_locked  = 1'b0;
      e_to      = 1'b0;
   endfunction

   function automatic void model_edge(input bit s);
      int j, hs, ref_edge;
      bit w, wp;
      vq.push_back(s);
      j  = vq.size();
      w  = (j >= 3) ? vq[j-3] : 1'b0;
      wp = (j >= 4) ? vq[j-4] : 1'b0;
      wq.push_back(w);
      e_mv = 1'b0;
      if (w && !wp) begin
         if (have_l && (j - last_rise) <= TO) begin
            hs = 0;
            for (int i = last_rise; i < j; i++) hs += int'(wq[i-1]);
            e_period = CNT_W'(j - last_rise);
            e_high   = CNT_W'(hs);
            e_mv     = 1'b1;
            e_locked = 1'b1;
            e_to     = 1'b0;
         end
         have_l    = 1'b1;
         last_rise = j;
      end else begin
         ref_edge = have_l ? last_rise : 0;
         if (j - ref_edge == TO) begin
            e_to     = 1'b1;
            e_locked = 1'b0;
         end
      end
   endfunction

   function automatic logic [2*CNT_W+2:0] dut_vec();
      return {period, high_time, meas_valid, locked, timeout};
   endfunction

   function automatic logic [2*CNT_W+2:0] model_vec();
      return {e_period, e_high, e_mv, e_locked, e_to};
   endfunction

   task automatic tick(input bit s);
      sig_in = s;
      @(posedge clk);
      model_edge(s);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      int first_to;
      sig_in = 1'b0;
      #2;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (dut_vec() !== '0) begin
         bad++;
         $display("FAIL reset_values got=%h want=0", dut_vec());
      end
      reset = 1'b0;
      model_reset();
      first_to = 0;
      for (int k = 1; k <= 60; k++) begin
         tick(1'b0);
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL idle edge %0d got=%h want=%h", k, dut_vec(), model_vec());
         end
         if (timeout === 1'b1 && first_to == 0) first_to = k;
      end
      total++;
      if (first_to !== 50) begin
         bad++;
         $display("FAIL idle_timeout_edge got=%0d want=50", first_to);
      end
   endtask

   // Periodic wave: hi edges high, lo edges low, starting high; caller resets.
   task automatic test_wave(input string name, input int hi, input int lo, input int n);
      int p, nmv, first_mv, last_mv;
      p        = hi + lo;
      nmv      = 0;
      first_mv = 0;
      last_mv  = 0;
      for (int k = 0; k < n; k++) begin
         tick((k % p) < hi);
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL %s edge %0d got=%h want=%h", name, k + 1, dut_vec(), model_vec());
         end
         total++;
         if (timeout !== 1'b0) begin
            bad++;
            $display("FAIL %s_no_timeout edge %0d got=%b want=0", name, k + 1, timeout);
         end
         if (meas_valid === 1'b1) begin
            nmv++;
            total++;
            if (period !== CNT_W'(p) || high_time !== CNT_W'(hi)) begin
               bad++;
               $display("FAIL %s_meas got=%0d/%0d want=%0d/%0d", name, period, high_time, p, hi);
            end
            if (nmv == 1) begin
               first_mv = k + 1;
            end else begin
               total++;
               if (k + 1 - last_mv !== p) begin
                  bad++;
                  $display("FAIL %s_spacing got=%0d want=%0d", name, k + 1 - last_mv, p);
               end
            end
            last_mv = k + 1;
         end
      end
      total++;
      if (first_mv !== p + 3 || locked !== 1'b1) begin
         bad++;
         $display("FAIL %s_first_lock got=%0d,%b want=%0d,1", name, first_mv, locked, p + 3);
      end
   endtask

   task automatic test_timeout_recover();
      int e, first_to, first_mv;
      do_reset();
      e        = 0;
      first_to = 0;
      first_mv = 0;
      for (int k = 0; k < 130; k++) begin
         e++;
         tick(k < 60 && (k % 10) < 5);
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL to_hold edge %0d got=%h want=%h", e, dut_vec(), model_vec());
         end
         if (timeout === 1'b1 && first_to == 0) begin
            first_to = e;
            total++;
            if (locked !== 1'b0 || period !== CNT_W'(10)) begin
               bad++;
               $display("FAIL to_state got=%b,%0d want=0,10", locked, period);
            end
         end
      end
      total++;
      if (first_to !== 103) begin
         bad++;
         $display("FAIL to_edge got=%0d want=103", first_to);
      end
      for (int k = 0; k < 40; k++) begin
         e++;
         tick((k % 10) < 5);
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL to_resume edge %0d got=%h want=%h", e, dut_vec(), model_vec());
         end
         if (meas_valid === 1'b1 && first_mv == 0) begin
            first_mv = e;
            total++;
            if (period !== CNT_W'(10) || timeout !== 1'b0) begin
               bad++;
               $display("FAIL to_resume_meas got=%0d,%b want=10,0", period, timeout);
            end
         end
      end
      total++;
      if (first_mv !== 143 || locked !== 1'b1 || timeout !== 1'b0) begin
         bad++;
         $display("FAIL to_relock got=%0d,%b,%b want=143,1,0", first_mv, locked, timeout);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int k = 0; k < 37; k++) tick((k % 10) < 5);
      #1;
      reset = 1'b1;
      #1;
      total++;
      if (dut_vec() !== '0) begin
         bad++;
         $display("FAIL async_reset got=%h want=0", dut_vec());
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      test_wave("after_reset", 5, 5, 40);
   endtask

   task automatic test_random();
      int e, len;
      bit lvl;
      do_reset();
      e   = 0;
      lvl = 1'b1;
      while (e < 1500) begin
         if (!lvl && $urandom_range(0, 7) == 0) len = $urandom_range(40, 80);
         else len = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) begin
            e++;
            tick(lvl);
            total++;
            if (dut_vec() !== model_vec()) begin
               bad++;
               $display("FAIL random edge %0d got=%h want=%h", e, dut_vec(), model_vec());
            end
         end
         lvl = ~lvl;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      do_reset();
      test_wave("sq10", 5, 5, 60);
      do_reset();
      test_wave("duty3of8", 3, 5, 50);
      test_timeout_recover();
      do_reset();
      test_wave("toggle", 1, 1, 20);
      do_reset();
      test_wave("edge_wins", 25, 25, 160);
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
